zone_buf_pingpong: RTL and testbench

- Parametrised, double-buffered per-zone gray store for the MiniLED backlight path.
- The gray calculator fills a write bank zone by zone. The dimming/driver side reads a stable, committed frame from the other bank.
- Banks swap on a frame-commit handshake. A read-side hold defers the swap so the driver never sees a torn frame.

---
 rtl/zone_buf_pingpong.sv | 152 +++++++++++++++
 tb/tb_zone_buf_pingpong.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/zone_buf_pingpong.sv
// Double-buffered per-zone gray store: the gray calculator fills one bank while the driver reads the committed other bank.
// Optional ZONE_PEAK_EN adds frame_peak/peak_zone: the brightest zone of each committed frame.
module zone_buf_pingpong #(
    parameter int unsigned ZONES = 360,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 9
) (
    input  logic          clk_x1,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          frame_done,
    input  logic          rd_hold,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          init_done,
    output logic          rd_bank,
    output logic          swap_pending,
    output logic [15:0]   frame_cnt,
    output logic [2:0]    err_flags
`ifdef ZONE_PEAK_EN
    ,
    output logic [DW-1:0] frame_peak,
    output logic [AW-1:0] peak_zone
`endif
);

    localparam logic [AW-1:0] LAST = AW'(ZONES - 1);

    typedef enum logic [1:0] {CLEAR, FILL, PEND} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] mem0 [ZONES];
    logic [DW-1:0] mem1 [ZONES];
    logic [DW-1:0] rd_word;
    logic          wr_ok;
    logic          swap;

    assign wr_ok = (state == FILL) && wr_en && (wr_addr <= LAST);
    assign swap  = ((state == FILL) && frame_done && !rd_hold) ||
                   ((state == PEND) && !rd_hold);

    // Bank storage: CLEAR zeroes both banks, FILL writes the bank not being read.
    always_ff @(posedge clk_x1) begin
        if (state == CLEAR) begin
            mem0[ptr] <= '0;
            mem1[ptr] <= '0;
        end else if (wr_ok) begin
            if (rd_bank) mem0[wr_addr] <= wr_data;
            else         mem1[wr_addr] <= wr_data;
        end
    end

    // Out-of-range addresses and not-yet-cleared banks read as zero.
    always_comb begin
        rd_word = '0;
        if ((state != CLEAR) && (rd_addr <= LAST))
            rd_word = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end

    // Control FSM, bank swap and read register.
    always_ff @(posedge clk_x1 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            ptr          <= '0;
            rd_bank      <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            init_done    <= 1'b0;
            swap_pending <= 1'b0;
            frame_cnt    <= '0;
            err_flags    <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
            if (swap) begin
                rd_bank   <= ~rd_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end
            case (state)
                CLEAR: begin
                    if (wr_en) err_flags[1] <= 1'b1;
                    if (ptr == LAST) begin
                        ptr   <= '0;
                        state <= FILL;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                FILL: begin
                    init_done <= 1'b1;
                    if (wr_en && (wr_addr > LAST)) err_flags[0] <= 1'b1;
                    if (frame_done && rd_hold) begin
                        state        <= PEND;
                        swap_pending <= 1'b1;
                    end
                end
                PEND: begin
                    if (wr_en)      err_flags[1] <= 1'b1;
                    if (frame_done) err_flags[2] <= 1'b1;
                    if (!rd_hold) begin
                        state        <= FILL;
                        swap_pending <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

`ifdef ZONE_PEAK_EN
    logic [DW-1:0] run_max, max_nx;
    logic [AW-1:0] run_zone, zone_nx;
    logic          run_vld;

    // First accepted write always captures; later ties keep the lower zone.
    always_comb begin
        max_nx  = run_max;
        zone_nx = run_zone;
        if (wr_ok && (!run_vld || (wr_data > run_max) ||
                      ((wr_data == run_max) && (wr_addr < run_zone)))) begin
            max_nx  = wr_data;
            zone_nx = wr_addr;
        end
    end

    always_ff @(posedge clk_x1 or negedge rst_n) begin
        if (!rst_n) begin
            run_max    <= '0;
            run_zone   <= '0;
            run_vld    <= 1'b0;
            frame_peak <= '0;
            peak_zone  <= '0;
        end else if (swap) begin
            frame_peak <= max_nx;
            peak_zone  <= zone_nx;
            run_max    <= '0;
            run_zone   <= '0;
            run_vld    <= 1'b0;
        end else begin
            run_max  <= max_nx;
            run_zone <= zone_nx;
            run_vld  <= run_vld | wr_ok;
        end
    end
`endif

endmodule

// File: tb/tb_zone_buf_pingpong.sv
// Randomized bench for zone_buf_pingpong against a frame-level reference model.
module tb_zone_buf_pingpong;

    localparam int ZONES = 360;
    localparam int DW    = 8;
    localparam int AW    = 9;

    logic          clk_x1 = 1'b0;
    logic          rst_n  = 1'b0;
    logic          wr_en = 1'b0, frame_done = 1'b0, rd_hold = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, init_done, rd_bank, swap_pending;
    logic [15:0]   frame_cnt;
    logic [2:0]    err_flags;
`ifdef ZONE_PEAK_EN
    logic [DW-1:0] frame_peak;
    logic [AW-1:0] peak_zone;
`endif

    always #5 clk_x1 = ~clk_x1;

    zone_buf_pingpong #(.ZONES(ZONES), .DW(DW), .AW(AW)) dut (
        .clk_x1(clk_x1), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .rd_hold(rd_hold),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done),
        .rd_bank(rd_bank), .swap_pending(swap_pending),
        .frame_cnt(frame_cnt), .err_flags(err_flags)
`ifdef ZONE_PEAK_EN
        , .frame_peak(frame_peak), .peak_zone(peak_zone)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: two frame arrays, a commit flag and a list of this fill's writes.
    logic [DW-1:0] mb [2][ZONES];
    int            tick;
    bit            m_bank, m_pend, m_valid;
    logic [15:0]   m_cnt;
    logic [2:0]    m_err;
    logic [DW-1:0] m_data;
    int            wq_a[$];
    int            wq_d[$];
    int            m_peak, m_pzone;

    task automatic model_reset();
        foreach (mb[b, z]) mb[b][z] = '0;
        tick = 0; m_bank = 0; m_pend = 0; m_valid = 0;
        m_cnt = '0; m_err = '0; m_data = '0;
        wq_a.delete(); wq_d.delete();
        m_peak = 0; m_pzone = 0;
    endtask

    task automatic commit();
        int best;
        m_bank = !m_bank;
        m_cnt  = m_cnt + 16'd1;
        best   = -1;
        foreach (wq_d[k]) if (wq_d[k] > best) best = wq_d[k];
        m_peak  = 0;
        m_pzone = 0;
        if (best >= 0) begin
            m_peak  = best;
            m_pzone = ZONES;
            foreach (wq_d[k]) if (wq_d[k] == best && wq_a[k] < m_pzone) m_pzone = wq_a[k];
        end
        wq_a.delete(); wq_d.delete();
    endtask

    task automatic model_step(input bit we, input int wa, input int wd, input bit fd,
                              input bit hold, input bit re, input int ra);
        bit in_clear;
        in_clear = (tick < ZONES);
        m_valid  = re;
        if (re) m_data = (in_clear || ra >= ZONES) ? '0 : mb[m_bank ? 1 : 0][ra];
        if (in_clear) begin
            if (we) m_err[1] = 1'b1;
        end else if (m_pend) begin
            if (we) m_err[1] = 1'b1;
            if (fd) m_err[2] = 1'b1;
            if (!hold) begin
                m_pend = 0;
                commit();
            end
        end else begin
            if (we) begin
                if (wa < ZONES) begin
                    mb[m_bank ? 0 : 1][wa] = DW'(wd);
                    wq_a.push_back(wa);
                    wq_d.push_back(wd);
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            if (fd) begin
                if (hold) m_pend = 1;
                else      commit();
            end
        end
        tick++;
    endtask

    task automatic check_all();
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_data", 32'(rd_data), 32'(m_data));
        check("init_done", 32'(init_done), 32'(tick >= ZONES + 1));
        check("rd_bank", 32'(rd_bank), 32'(m_bank));
        check("swap_pending", 32'(swap_pending), 32'(m_pend));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        check("err_flags", 32'(err_flags), 32'(m_err));
`ifdef ZONE_PEAK_EN
        check("frame_peak", 32'(frame_peak), 32'(m_peak));
        check("peak_zone", 32'(peak_zone), 32'(m_pzone));
`endif
    endtask

    // Called just after a falling edge: drive, predict, sample 1 ns after the rising edge.
    task automatic step(input bit we, input int wa, input int wd, input bit fd,
                        input bit hold, input bit re, input int ra);
        wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
        frame_done = fd; rd_hold = hold; rd_en = re; rd_addr = AW'(ra);
        model_step(we, wa, wd, fd, hold, re, ra);
        @(posedge clk_x1);
        #1;
        check_all();
        @(negedge clk_x1);
    endtask

    task automatic reset_dut();
        #2;
        rst_n = 1'b0;
        wr_en = 0; frame_done = 0; rd_hold = 0; rd_en = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk_x1);
        @(negedge clk_x1);
        rst_n = 1'b1;
    endtask

    bit r_hold = 0;

    task automatic rand_step();
        int wa, ra;
        if ($urandom_range(0, 19) == 0) r_hold = !r_hold;
        wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(ZONES, 511)) : int'($urandom_range(0, ZONES - 1));
        ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(ZONES, 511)) : int'($urandom_range(0, ZONES - 1));
        step(bit'($urandom_range(0, 1)), wa, int'($urandom_range(0, 255)),
             $urandom_range(0, 39) == 0, r_hold, bit'($urandom_range(0, 1)), ra);
    endtask

    initial begin
        @(negedge clk_x1);
        reset_dut();

        // Clear phase with reads every cycle, then a sweep of the cleared bank.
        for (int i = 0; i < ZONES + 2; i++) step(0, 0, 0, 0, 0, 1, i % ZONES);
        check("init_done_risen", 32'(init_done), 32'd1);
        for (int i = 0; i < ZONES; i++) step(0, 0, 0, 0, 0, 1, i);

        // Frame 1: zone i holds i[7:0], committed without hold.
        for (int i = 0; i < ZONES; i++) step(1, i, i & 255, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("f1_bank", 32'(rd_bank), 32'd1);
        check("f1_cnt", 32'(frame_cnt), 32'd1);
        step(0, 0, 0, 0, 0, 1, 5);
        check("f1_rd5", 32'(rd_data), 32'd5);
        step(0, 0, 0, 0, 0, 1, 359);
        check("f1_rd359", 32'(rd_data), 32'd103);

        // Frame 2 under hold: commit waits, extra write dropped.
        for (int i = 0; i < ZONES; i++) step(1, i, 8'hAA, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        check("f2_pending", 32'(swap_pending), 32'd1);
        step(0, 0, 0, 0, 1, 1, 5);
        check("f2_rd5_held", 32'(rd_data), 32'd5);
        step(1, 10, 8'h55, 0, 1, 0, 0);
        check("f2_err1", 32'(err_flags[1]), 32'd1);
        step(0, 0, 0, 0, 0, 1, 5);
        check("f2_rd5_swap_cycle", 32'(rd_data), 32'd5);
        step(0, 0, 0, 0, 0, 1, 5);
        check("f2_rd5_new", 32'(rd_data), 32'hAA);
        check("f2_cnt", 32'(frame_cnt), 32'd2);

        // Out-of-range write is discarded; full sweep after commit.
        step(1, 360, 8'hFF, 0, 0, 0, 0);
        check("oor_err0", 32'(err_flags[0]), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < ZONES; i++) step(0, 0, 0, 0, 0, 1, i);

        // Write coincident with frame_done belongs to the committed frame.
        step(1, 7, 8'h33, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7);
        check("coinc_rd7", 32'(rd_data), 32'h33);

        // Peak tracking with a tie at the maximum.
        step(1, 3, 8'h10, 0, 0, 0, 0);
        step(1, 100, 8'hF0, 0, 0, 0, 0);
        step(1, 200, 8'hF0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
`ifdef ZONE_PEAK_EN
        check("peak_val", 32'(frame_peak), 32'hF0);
        check("peak_zone_dir", 32'(peak_zone), 32'd100);
`endif

        repeat (3000) rand_step();

        // Reset mid-frame, then again mid-clear.
        reset_dut();
        r_hold = 0;
        repeat (100) rand_step();
        reset_dut();
        r_hold = 0;
        repeat (ZONES + 600) rand_step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
